dot_seq_ctrl: RTL and testbench

Sequencing controller for multi-chunk dot products on the 4-lane, 32-bit vector datapath. It accepts a job of `len` chunks, where each chunk is four 32-bit lanes per operand. It streams the chunks in over a valid/ready handshake and accumulates the per-chunk lane-product sums modulo 2^32. It then presents one 32-bit result over a valid/ready output handshake. It sits between the instruction-issue logic and the vector operand buffers, and extends the single-chunk dot-product operation to vectors of arbitrary length.

---
 rtl/dot_seq_ctrl_if.sv | 37 +++
 rtl/dot_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_dot_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_seq_ctrl_if.sv
// Bus bundle between the instruction-issue side (master) and the
// multi-chunk dot-product sequencer (slave).
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds its payload stable
// while valid is high and ready is low. The sink's ready is not allowed to
// depend combinationally on valid.
interface dot_seq_ctrl_if #(
    parameter int LEN_W = 8
);
    // job control
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;

    // chunk input stream
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     vec_a;
    logic [127:0]     vec_b;

    // result output stream
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      dot_result;

    modport master (
        output start, len, abort, in_valid, vec_a, vec_b, out_ready,
        input  busy, in_ready, out_valid, dot_result
    );

    modport slave (
        input  start, len, abort, in_valid, vec_a, vec_b, out_ready,
        output busy, in_ready, out_valid, dot_result
    );
endinterface

// File: rtl/dot_seq_ctrl.sv
// Multi-chunk dot-product sequencer. It accepts a job of len chunks, where each
// chunk is four 32-bit lanes per operand. It accumulates the lane-product sums
// modulo 2^32 and hands back one 32-bit result. in_ready and out_valid are
// decoded from the registered state only.
module dot_seq_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dot_seq_ctrl_if.slave        bus,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_acc;
    logic [LEN_W-1:0] r_remaining;
    logic [31:0]      r_result;

    logic             w_load_job;
    logic             w_load_zero;
    logic             w_beat;
    logic             w_finish;
    logic [31:0]      w_chunk_sum;
    logic [31:0]      w_acc_sum;

    // Sum of the four lane products, every step truncated to 32 bits.
    always_comb begin
        w_chunk_sum = 32'd0;
        for (int i = 0; i < 4; i++) begin
            w_chunk_sum = w_chunk_sum + (bus.vec_a[32*i +: 32] * bus.vec_b[32*i +: 32]);
        end
        w_acc_sum = r_acc + w_chunk_sum;
    end

    // Next-state decode and datapath strobes; abort wins over a same-cycle beat.
    always_comb begin
        w_next_state = r_state;
        w_load_job   = 1'b0;
        w_load_zero  = 1'b0;
        w_beat       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        w_load_job   = 1'b1;
                        w_next_state = ACCUM;
                    end else begin
                        w_load_zero  = 1'b1;
                        w_next_state = DONE;
                    end
                end
            end
            ACCUM: begin
                if (bus.abort) begin
                    w_next_state = IDLE;
                end else if (bus.in_valid) begin
                    w_beat = 1'b1;
                    if (r_remaining == LEN_W'(1)) begin
                        w_finish     = 1'b1;
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Accumulator, chunk counter and held result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= 32'd0;
            r_remaining <= '0;
            r_result    <= 32'd0;
        end else begin
            if (w_load_job) begin
                r_acc       <= 32'd0;
                r_remaining <= bus.len;
            end
            if (w_load_zero) begin
                r_result <= 32'd0;
            end
            if (w_beat) begin
                r_acc       <= w_acc_sum;
                r_remaining <= r_remaining - LEN_W'(1);
            end
            if (w_finish) begin
                r_result <= w_acc_sum;
            end
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.in_ready   = (r_state == ACCUM);
    assign bus.out_valid  = (r_state == DONE);
    assign bus.dot_result = r_result;
    assign o_state        = r_state;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed bench for dot_seq_ctrl. Inputs are driven 1 ns after each rising
// edge, and outputs are sampled at the same point. A value seen after
// tick() is therefore the registered value for the cycle that follows that edge.
module tb_dot_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  dut_state;
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    dot_seq_ctrl_if #(.LEN_W(8)) bus ();

    dot_seq_ctrl #(.LEN_W(8)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus),
        .o_state (dut_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drivers
    task automatic drive_idle();
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.vec_a     = '0;
        bus.vec_b     = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_lanes(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
        bus.vec_a = {a3, a2, a1, a0};
        bus.vec_b = {b3, b2, b1, b0};
    endtask

    task automatic launch(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        tick();
        bus.start = 1'b0;
        bus.len   = 8'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        n_checks++; if (bus.dot_result !== 32'd0) begin n_errors++; $display("FAIL reset_result: got %0h expected 0", bus.dot_result); end
        n_checks++; if (dut_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dut_state); end
    endtask

    task automatic test_single();
        exp_q.push_back(32'd70);
        launch(8'd1);
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %0b expected 1", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL single_in_ready: got %0b expected 1", bus.in_ready); end
        bus.in_valid = 1'b1;
        drive_lanes(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
        tick();
        bus.in_valid = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL single_out_valid: got %0b expected 1", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL single_in_ready_done: got %0b expected 0", bus.in_ready); end
        n_checks++; if (bus.dot_result !== exp_v) begin n_errors++; $display("FAIL single_result: got %0h expected %0h", bus.dot_result, exp_v); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL single_return_idle: busy %0b out_valid %0b expected 0 0", bus.busy, bus.out_valid); end
        n_checks++; if (bus.dot_result !== exp_v) begin n_errors++; $display("FAIL single_result_kept: got %0h expected %0h", bus.dot_result, exp_v); end
    endtask

    task automatic test_stall();
        exp_q.push_back(32'd12);
        launch(8'd3);
        drive_lanes(32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL stall_ready_beat%0d: got %0b expected 1", i, bus.in_ready); end
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL stall_gap%0d_%0d: out_valid %0b in_ready %0b expected 0 1", i, g, bus.out_valid, bus.in_ready); end
                    tick();
                end
            end
        end
        exp_v = exp_q.pop_front();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_out_valid: got %0b expected 1", bus.out_valid); end
        n_checks++; if (bus.dot_result !== exp_v) begin n_errors++; $display("FAIL stall_result: got %0h expected %0h", bus.dot_result, exp_v); end
        // in_valid in DONE must not disturb the held result
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.dot_result !== exp_v || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_hold: result %0h out_valid %0b expected %0h 1", bus.dot_result, bus.out_valid, exp_v); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cycles;
        exp_q.push_back(32'hFFFF_FFFE);
        bus.out_ready = 1'b1;
        launch(8'd2);
        cycles = 1;
        bus.in_valid = 1'b1;
        drive_lanes(32'h0001_0000, 32'd0, 32'd0, 32'd0, 32'h0001_0000, 32'd0, 32'd0, 32'd0);
        tick();
        cycles++;
        drive_lanes(32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd2);
        n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_mid: in_ready %0b out_valid %0b expected 1 0", bus.in_ready, bus.out_valid); end
        tick();
        cycles++;
        bus.in_valid = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_out_valid: got %0b expected 1", bus.out_valid); end
        n_checks++; if (bus.dot_result !== exp_v) begin n_errors++; $display("FAIL wrap_result: got %0h expected %0h", bus.dot_result, exp_v); end
        tick();
        cycles++;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: busy %0b expected 0", bus.busy); end
        n_checks++; if (cycles !== 4) begin n_errors++; $display("FAIL b2b_job_cycles: got %0d expected 4", cycles); end
    endtask

    task automatic test_len_zero();
        launch(8'd0);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin n_errors++; $display("FAIL len0_out_valid: out_valid %0b busy %0b expected 1 1", bus.out_valid, bus.busy); end
        n_checks++; if (bus.dot_result !== 32'd0) begin n_errors++; $display("FAIL len0_result: got %0h expected 0", bus.dot_result); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL len0_in_ready: got %0b expected 0", bus.in_ready); end
        drive_lanes(32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9);
        for (int i = 0; i < 5; i++) begin
            bus.start    = (i % 2 == 0);
            bus.len      = 8'd5;
            bus.in_valid = 1'b1;
            bus.abort    = (i == 3);
            tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.dot_result !== 32'd0) begin
                n_errors++; $display("FAIL len0_hold%0d: out_valid %0b in_ready %0b busy %0b result %0h expected 1 0 1 0", i, bus.out_valid, bus.in_ready, bus.busy, bus.dot_result);
            end
        end
        drive_idle();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL len0_release: busy %0b out_valid %0b expected 0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_abort();
        launch(8'd4);
        drive_lanes(32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2);
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL abort_idle: busy %0b in_ready %0b out_valid %0b expected 0 0 0", bus.busy, bus.in_ready, bus.out_valid); end
        n_checks++; if (bus.dot_result !== 32'd0) begin n_errors++; $display("FAIL abort_result: got %0h expected 0", bus.dot_result); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL abort_no_out%0d: got %0b expected 0", i, bus.out_valid); end
        end
        bus.out_ready = 1'b0;
        // abort alongside start in IDLE has no effect
        exp_q.push_back(32'd4);
        bus.abort = 1'b1;
        launch(8'd1);
        bus.abort = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL abort_idle_ignored: in_ready %0b expected 1", bus.in_ready); end
        drive_lanes(32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.dot_result !== exp_v) begin n_errors++; $display("FAIL abort_next_job: out_valid %0b result %0h expected 1 %0h", bus.out_valid, bus.dot_result, exp_v); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        launch(8'd3);
        drive_lanes(32'd1, 32'd1, 32'd1, 32'd1, 32'd3, 32'd3, 32'd3, 32'd3);
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.dot_result !== 32'd0) begin
            n_errors++; $display("FAIL rst_accum: busy %0b in_ready %0b out_valid %0b result %0h expected 0 0 0 0", bus.busy, bus.in_ready, bus.out_valid, bus.dot_result);
        end
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL rst_job_lost: out_valid %0b busy %0b expected 0 0", bus.out_valid, bus.busy); end
        launch(8'd1);
        drive_lanes(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.dot_result !== 32'd70) begin n_errors++; $display("FAIL rst_pre_done: out_valid %0b result %0h expected 1 46", bus.out_valid, bus.dot_result); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.dot_result !== 32'd0) begin
            n_errors++; $display("FAIL rst_done: busy %0b in_ready %0b out_valid %0b result %0h expected 0 0 0 0", bus.busy, bus.in_ready, bus.out_valid, bus.dot_result);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_len_zero();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
